// File: rtl/block_packer_if.sv
// Handshake bundle for block_packer: upstream FIFO read side and downstream block side.
// The packer connects through the master modport; the FIFO/consumer environment uses slave.
interface block_packer_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 16
) ();
  localparam int BLK_W = DATA_W * NUM_WORDS;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_pop;
  logic              flush;
  logic              blk_valid;
  logic              blk_ready;
  logic [BLK_W-1:0]  blk_data;
  logic [CNT_W-1:0]  blk_count;
  logic              busy;

  modport master (
    input  fifo_empty, fifo_data, flush, blk_ready,
    output fifo_pop, blk_valid, blk_data, blk_count, busy
  );

  modport slave (
    output fifo_empty, fifo_data, flush, blk_ready,
    input  fifo_pop, blk_valid, blk_data, blk_count, busy
  );
endinterface

// File: rtl/block_packer.sv
// Pops NUM_WORDS words from a 1-cycle-latency FIFO and presents them as one block
// on a valid/ready port, with zero-padded partial flush and selectable word order.
module block_packer #(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           n_rst,
  block_packer_if.master bus
);
  localparam int BLK_W = DATA_W * NUM_WORDS;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_WORDS);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             pop_q;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             pop;

  // Gated by n_rst so the FIFO is never popped while the packer is held in reset.
  assign pop = n_rst && (state_q == ST_FILL) && !bus.fifo_empty && !bus.flush &&
               (issued_q < FULL);

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    issued_d = issued_q;
    blk_d    = blk_q;
    if (pop) issued_d = issued_q + 1'b1;
    case (state_q)
      ST_FILL: begin
        if (pop_q) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (count_q == CNT_W'(k)) begin
              if (MSB_FIRST) blk_d[BLK_W-1-k*DATA_W -: DATA_W] = bus.fifo_data;
              else           blk_d[k*DATA_W +: DATA_W]         = bus.fifo_data;
            end
          end
          count_d = count_q + 1'b1;
          if (count_d == FULL) state_d = ST_HOLD;
        end else if (bus.flush && (count_q != '0)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.blk_ready) begin
          state_d  = ST_FILL;
          count_d  = '0;
          issued_d = '0;
          blk_d    = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // NOTE: blk_q is a plain register, not a RAM; it is reset so flushed blocks pad with zeros.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_FILL;
      count_q  <= '0;
      issued_q <= '0;
      pop_q    <= 1'b0;
      blk_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of order.
      state_q  <= state_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      pop_q    <= pop;
      blk_q    <= blk_d;
    end
  end

  assign bus.fifo_pop  = pop;
  assign bus.blk_valid = (state_q == ST_HOLD);
  assign bus.blk_data  = blk_q;
  assign bus.blk_count = count_q;
  assign bus.busy      = (count_q != '0) || pop_q || (state_q == ST_HOLD);
endmodule
